// File: rtl/mem_arb.sv
// Two-port memory arbiter between the pipeline memory stage and a DMA engine.
// Define MEM_ARB_STARVE_EN to build the DMA starvation-promotion counters.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 16
`endif

module mem_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst_n,
  input  logic                  iw_p_req,
  input  logic                  iw_p_mp,
  input  logic                  iw_p_we,
  input  logic [`SIZE_ADDR-1:0] iw_p_addr,
  input  logic [`SIZE_DATA-1:0] iw_p_wdata,
  input  logic                  iw_d_req,
  input  logic                  iw_d_mp,
  input  logic                  iw_d_we,
  input  logic [`SIZE_ADDR-1:0] iw_d_addr,
  input  logic [`SIZE_DATA-1:0] iw_d_wdata,
  output logic                  ow_p_gnt,
  output logic                  ow_d_gnt,
  output logic                  ow_p_stall,
  output logic                  ow_p_rvalid,
  output logic                  ow_d_rvalid,
  output logic [`SIZE_DATA-1:0] ow_p_rdata,
  output logic [`SIZE_DATA-1:0] ow_d_rdata,
  output logic                  ow_mem_en    [0:1],
  output logic                  ow_mem_we    [0:1],
  output logic [`SIZE_ADDR-1:0] ow_mem_addr  [0:1],
  output logic [`SIZE_DATA-1:0] ow_mem_wdata [0:1],
  input  logic [`SIZE_DATA-1:0] iw_mem_rdata [0:1]
);

  logic [1:0] p_tgt;
  logic [1:0] d_tgt;
  logic [1:0] p_win;
  logic [1:0] d_win;
  logic [1:0] promote;
  logic       p_pend;
  logic       p_port;
  logic       d_pend;
  logic       d_port;

  // Reset gates targeting so no grant or memory enable escapes during reset
  assign p_tgt = {2{iw_rst_n & iw_p_req}} & {iw_p_mp, ~iw_p_mp};
  assign d_tgt = {2{iw_rst_n & iw_d_req}} & {iw_d_mp, ~iw_d_mp};

  assign p_win = p_tgt & (~d_tgt | ~promote);
  assign d_win = d_tgt & (~p_tgt | promote);

  assign ow_p_gnt   = |p_win;
  assign ow_d_gnt   = |d_win;
  assign ow_p_stall = iw_p_req & ~ow_p_gnt;

`ifdef MEM_ARB_STARVE_EN
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt [0:1];

  assign promote = {starve_cnt[1] == LIMIT, starve_cnt[0] == LIMIT};

  // DMA starvation counters: count lost conflicts, clear on any DMA grant
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      starve_cnt[0] <= '0;
      starve_cnt[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (d_win[k]) begin
          starve_cnt[k] <= '0;
        end else if (p_tgt[k] && d_tgt[k] && (starve_cnt[k] != LIMIT)) begin
          starve_cnt[k] <= starve_cnt[k] + 1'b1;
        end else begin
          starve_cnt[k] <= starve_cnt[k];
        end
      end
    end
  end
`else
  assign promote = 2'b00;
`endif

  // Memory port drive from whichever requester won the port
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      ow_mem_en[k]    = p_win[k] | d_win[k];
      ow_mem_we[k]    = 1'b0;
      ow_mem_addr[k]  = '0;
      ow_mem_wdata[k] = '0;
      if (p_win[k]) begin
        ow_mem_we[k]    = iw_p_we;
        ow_mem_addr[k]  = iw_p_addr;
        ow_mem_wdata[k] = iw_p_wdata;
      end else if (d_win[k]) begin
        ow_mem_we[k]    = iw_d_we;
        ow_mem_addr[k]  = iw_d_addr;
        ow_mem_wdata[k] = iw_d_wdata;
      end else begin
        ow_mem_we[k]    = 1'b0;
      end
    end
  end

  // Remember which port each granted read went to for next-cycle return
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      p_pend <= 1'b0;
      p_port <= 1'b0;
      d_pend <= 1'b0;
      d_port <= 1'b0;
    end else begin
      p_pend <= ow_p_gnt & ~iw_p_we;
      p_port <= iw_p_mp;
      d_pend <= ow_d_gnt & ~iw_d_we;
      d_port <= iw_d_mp;
    end
  end

  // Memory data is valid the cycle after enable, so it is steered straight out
  assign ow_p_rvalid = p_pend;
  assign ow_d_rvalid = d_pend;
  assign ow_p_rdata  = p_pend ? iw_mem_rdata[p_port] : '0;
  assign ow_d_rdata  = d_pend ? iw_mem_rdata[d_port] : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a cycle-level reference model and a
// behavioural two-port memory; expectations follow MEM_ARB_STARVE_EN.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 16
`endif

module tb_mem_arb;
  localparam int LIMIT = 4;
`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        p_req, p_mp, p_we, d_req, d_mp, d_we;
  logic [15:0] p_addr, p_wdata, d_addr, d_wdata;
  logic        p_gnt, d_gnt, p_stall, p_rvalid, d_rvalid;
  logic [15:0] p_rdata, d_rdata;
  logic        mem_en    [0:1];
  logic        mem_we    [0:1];
  logic [15:0] mem_addr  [0:1];
  logic [15:0] mem_wdata [0:1];
  logic [15:0] mem_rdata [0:1];

  int n_pass  = 0;
  int n_total = 0;
  bit chk_on  = 1'b0;

  mem_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .iw_clk(clk), .iw_rst_n(rst_n),
    .iw_p_req(p_req), .iw_p_mp(p_mp), .iw_p_we(p_we),
    .iw_p_addr(p_addr), .iw_p_wdata(p_wdata),
    .iw_d_req(d_req), .iw_d_mp(d_mp), .iw_d_we(d_we),
    .iw_d_addr(d_addr), .iw_d_wdata(d_wdata),
    .ow_p_gnt(p_gnt), .ow_d_gnt(d_gnt), .ow_p_stall(p_stall),
    .ow_p_rvalid(p_rvalid), .ow_d_rvalid(d_rvalid),
    .ow_p_rdata(p_rdata), .ow_d_rdata(d_rdata),
    .ow_mem_en(mem_en), .ow_mem_we(mem_we),
    .ow_mem_addr(mem_addr), .ow_mem_wdata(mem_wdata),
    .iw_mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] init_word(input int k, input int a);
    if (k == 0 && a == 16) return 16'hBEEF;
    return 16'(32'h1000 * (k + 1) + a);
  endfunction

  // Behavioural synchronous RAM, one per port, one-cycle read latency
  logic [15:0] ram [0:1][0:255];
  bit          ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int k = 0; k < 2; k++)
        for (int a = 0; a < 256; a++) ram[k][a] <= init_word(k, a);
      ram_ready <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (mem_en[k] && mem_we[k]) ram[k][mem_addr[k][7:0]] <= mem_wdata[k];
        else if (mem_en[k]) mem_rdata[k] <= ram[k][mem_addr[k][7:0]];
      end
    end
  end

  // Reference model state
  int          starve [0:1];
  bit          exp_rv_p, exp_rv_d;
  logic [15:0] exp_rd_p, exp_rd_d;
  logic [15:0] shadow [0:1][0:255];
  bit          shadow_ready = 1'b0;

  // Returns {dma wins port1, dma wins port0, pipe wins port1, pipe wins port0}
  function automatic logic [3:0] model_grants();
    logic [1:0] pw, dw;
    bit pt, dt;
    pw = 2'b00;
    dw = 2'b00;
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        pt = p_req && (int'(p_mp) == k);
        dt = d_req && (int'(d_mp) == k);
        if (pt && dt) begin
          if (STARVE_ON && starve[k] == LIMIT) dw[k] = 1'b1;
          else pw[k] = 1'b1;
        end else begin
          pw[k] = pt;
          dw[k] = dt;
        end
      end
    end
    return {dw, pw};
  endfunction

  always @(posedge clk) begin
    logic [3:0] g;
    if (!shadow_ready) begin
      for (int k = 0; k < 2; k++)
        for (int a = 0; a < 256; a++) shadow[k][a] <= init_word(k, a);
      shadow_ready <= 1'b1;
    end
    if (!rst_n) begin
      starve[0] <= 0;
      starve[1] <= 0;
      exp_rv_p  <= 1'b0;
      exp_rv_d  <= 1'b0;
      exp_rd_p  <= 16'h0000;
      exp_rd_d  <= 16'h0000;
    end else begin
      g = model_grants();
      exp_rv_p <= (|g[1:0]) && !p_we;
      exp_rd_p <= ((|g[1:0]) && !p_we) ? shadow[p_mp][p_addr[7:0]] : 16'h0000;
      exp_rv_d <= (|g[3:2]) && !d_we;
      exp_rd_d <= ((|g[3:2]) && !d_we) ? shadow[d_mp][d_addr[7:0]] : 16'h0000;
      for (int k = 0; k < 2; k++) begin
        if (g[k] && p_we) shadow[k][p_addr[7:0]] <= p_wdata;
        if (g[k+2] && d_we) shadow[k][d_addr[7:0]] <= d_wdata;
        if (g[k+2]) starve[k] <= 0;
        else if (p_req && d_req && int'(p_mp) == k && int'(d_mp) == k)
          starve[k] <= (starve[k] < LIMIT) ? starve[k] + 1 : LIMIT;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
    else n_pass++;
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic [3:0] g;
    if (chk_on) begin
      g = model_grants();
      chk("p_gnt", 32'(p_gnt), 32'(|g[1:0]));
      chk("d_gnt", 32'(d_gnt), 32'(|g[3:2]));
      chk("p_stall", 32'(p_stall), 32'(p_req && !(|g[1:0])));
      chk("p_rvalid", 32'(p_rvalid), 32'(rst_n && exp_rv_p));
      chk("d_rvalid", 32'(d_rvalid), 32'(rst_n && exp_rv_d));
      chk("p_rdata", 32'(p_rdata), rst_n ? 32'(exp_rd_p) : 32'h0);
      chk("d_rdata", 32'(d_rdata), rst_n ? 32'(exp_rd_d) : 32'h0);
      for (int k = 0; k < 2; k++) begin
        chk("mem_en", 32'(mem_en[k]), 32'(g[k] | g[k+2]));
        chk("mem_we", 32'(mem_we[k]), g[k] ? 32'(p_we) : (g[k+2] ? 32'(d_we) : 32'h0));
        chk("mem_addr", 32'(mem_addr[k]), g[k] ? 32'(p_addr) : (g[k+2] ? 32'(d_addr) : 32'h0));
        chk("mem_wdata", 32'(mem_wdata[k]), g[k] ? 32'(p_wdata) : (g[k+2] ? 32'(d_wdata) : 32'h0));
      end
    end
  end

  task automatic drive_p(input bit req, input bit mp, input bit we, input logic [15:0] a, input logic [15:0] wd);
    p_req = req; p_mp = mp; p_we = we; p_addr = a; p_wdata = wd;
  endtask
  task automatic drive_d(input bit req, input bit mp, input bit we, input logic [15:0] a, input logic [15:0] wd);
    d_req = req; d_mp = mp; d_we = we; d_addr = a; d_wdata = wd;
  endtask
  task automatic idle();
    drive_p(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive_d(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #3;
  endtask

  bit exp_p_31 [0:5];
  bit exp_d_31 [0:5];

  initial begin
    rst_n = 1'b0;
    idle();
    chk_on = 1'b1;
    settle();
    chk("reset p_rvalid", 32'(p_rvalid), 32'h0);
    chk("reset mem_en0", 32'(mem_en[0]), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Pipeline read of port 0, address 0x10
    drive_p(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    settle();
    chk("rd p_gnt", 32'(p_gnt), 32'h1);
    chk("rd mem_addr0", 32'(mem_addr[0]), 32'h0010);
    tick();
    idle();
    settle();
    chk("rd p_rvalid", 32'(p_rvalid), 32'h1);
    chk("rd p_rdata", 32'(p_rdata), 32'hBEEF);
    chk("rd d_rvalid", 32'(d_rvalid), 32'h0);
    tick();
    settle();
    chk("rd pulse end", 32'(p_rvalid), 32'h0);

    // Pipeline write port 1 alongside DMA read port 0
    drive_p(1'b1, 1'b1, 1'b1, 16'h0020, 16'hCAFE);
    drive_d(1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000);
    settle();
    chk("wr p_gnt", 32'(p_gnt), 32'h1);
    chk("wr d_gnt", 32'(d_gnt), 32'h1);
    chk("wr mem_we1", 32'(mem_we[1]), 32'h1);
    chk("wr mem_wdata1", 32'(mem_wdata[1]), 32'hCAFE);
    tick();
    idle();
    settle();
    chk("wr d_rvalid", 32'(d_rvalid), 32'h1);
    chk("wr d_rdata", 32'(d_rdata), 32'h1005);
    chk("wr p_rvalid", 32'(p_rvalid), 32'h0);
    tick();
    settle();
    chk("wr d pulse end", 32'(d_rvalid), 32'h0);

    // Simultaneous reads on different ports, including the written word
    drive_p(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000);
    drive_d(1'b1, 1'b0, 1'b0, 16'h0007, 16'h0000);
    tick();
    idle();
    settle();
    chk("dual p_rdata", 32'(p_rdata), 32'hCAFE);
    chk("dual d_rdata", 32'(d_rdata), 32'h1007);
    chk("dual d_rvalid", 32'(d_rvalid), 32'h1);

    // Back-to-back pipeline reads on port 1
    for (int i = 1; i <= 3; i++) begin
      drive_p(1'b1, 1'b1, 1'b0, 16'(i), 16'h0000);
      tick();
      settle();
      chk("b2b p_rvalid", 32'(p_rvalid), 32'h1);
      chk("b2b p_rdata", 32'(p_rdata), 32'h2000 + 32'(i));
    end
    idle();
    tick();

    // Sustained conflict on port 0
    for (int c = 0; c < 6; c++) begin
      exp_p_31[c] = !(STARVE_ON && c == 4);
      exp_d_31[c] = STARVE_ON && c == 4;
    end
    for (int c = 0; c < 6; c++) begin
      drive_p(1'b1, 1'b0, 1'b0, 16'(8'h40 + c), 16'h0000);
      drive_d(1'b1, 1'b0, 1'b0, 16'h0050, 16'h0000);
      settle();
      chk("starve p_gnt", 32'(p_gnt), 32'(exp_p_31[c]));
      chk("starve d_gnt", 32'(d_gnt), 32'(exp_d_31[c]));
      chk("starve p_stall", 32'(p_stall), 32'(exp_d_31[c]));
      tick();
    end
    idle();
    tick();

    // Reset the cycle after a granted read
    drive_p(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    tick();
    rst_n = 1'b0;
    idle();
    settle();
    chk("rst p_rvalid", 32'(p_rvalid), 32'h0);
    chk("rst p_rdata", 32'(p_rdata), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    chk("post-rst p_rvalid", 32'(p_rvalid), 32'h0);
    chk("post-rst mem_en0", 32'(mem_en[0]), 32'h0);
    tick();

    // First arbitration after release
    drive_p(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    settle();
    chk("resume p_gnt", 32'(p_gnt), 32'h1);
    tick();
    idle();
    settle();
    chk("resume p_rdata", 32'(p_rdata), 32'hBEEF);
    tick();
    tick();

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
